enigma_char_sequencer: RTL and testbench

- Sequential front-end that drives the combinational rotor/reflect lookup chain one character at a time.
- Accepts a plaintext or ciphertext character over a valid/ready handshake and steps the three rotor positions odometer-style before each lookup.
- Presents the current character and positions to the chain, waits a programmable settle time, then returns the result over an output valid/ready handshake.
- Sits between the UART/keyboard character stream and the rotor/reflector datapath. The same block serves encryption and decryption, since Enigma is symmetric.

---
 rtl/enigma_pkg.sv | 25 ++
 rtl/rotor_position_stepper.sv | 43 ++++
 rtl/enigma_char_sequencer.sv | 128 ++++++++++++
 tb/tb_enigma_char_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and modular helpers for the Enigma character sequencer.
package enigma_pkg;

    localparam int unsigned ALPHA      = 26;
    localparam int unsigned CHAR_W     = 5;
    localparam int unsigned NOTCH0_DEF = 16;
    localparam int unsigned NOTCH1_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        LOOK = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic [CHAR_W-1:0] mod_inc(input logic [CHAR_W-1:0] pos);
        return (pos == CHAR_W'(ALPHA - 1)) ? '0 : pos + CHAR_W'(1);
    endfunction

    // Key values 26..31 fold back into the alphabet by a single subtraction.
    function automatic logic [CHAR_W-1:0] mod_reduce(input logic [CHAR_W-1:0] pos);
        return (pos >= CHAR_W'(ALPHA)) ? pos - CHAR_W'(ALPHA) : pos;
    endfunction

endpackage

// File: rtl/rotor_position_stepper.sv
// Three rotor position registers with key load and odometer/double-step advance.
module rotor_position_stepper
    import enigma_pkg::*;
#(
    parameter int unsigned NOTCH0 = NOTCH0_DEF,
    parameter int unsigned NOTCH1 = NOTCH1_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [CHAR_W-1:0] key_pos0,
    input  logic [CHAR_W-1:0] key_pos1,
    input  logic [CHAR_W-1:0] key_pos2,
    output logic [CHAR_W-1:0] pos0,
    output logic [CHAR_W-1:0] pos1,
    output logic [CHAR_W-1:0] pos2
);

    logic carry1_c;
    logic carry2_c;

    // Rotor1 sitting on its notch advances itself too: the double step.
    assign carry1_c = (pos0 == CHAR_W'(NOTCH0)) || (pos1 == CHAR_W'(NOTCH1));
    assign carry2_c = (pos1 == CHAR_W'(NOTCH1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos0 <= '0;
            pos1 <= '0;
            pos2 <= '0;
        end else if (load) begin
            pos0 <= mod_reduce(key_pos0);
            pos1 <= mod_reduce(key_pos1);
            pos2 <= mod_reduce(key_pos2);
        end else if (step) begin
            pos0 <= mod_inc(pos0);
            if (carry1_c) pos1 <= mod_inc(pos1);
            if (carry2_c) pos2 <= mod_inc(pos2);
        end
    end

endmodule

// File: rtl/enigma_char_sequencer.sv
// One-character-at-a-time front end for the rotor/reflector lookup chain:
// accept, step rotors, settle the lookup, then hand the result downstream.
module enigma_char_sequencer
    import enigma_pkg::*;
#(
    parameter int unsigned NOTCH0        = NOTCH0_DEF,
    parameter int unsigned NOTCH1        = NOTCH1_DEF,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [CHAR_W-1:0] key_pos0,
    input  logic [CHAR_W-1:0] key_pos1,
    input  logic [CHAR_W-1:0] key_pos2,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    output logic              in_ready,
    output logic [CHAR_W-1:0] rotor_char,
    output logic [CHAR_W-1:0] rotor_pos0,
    output logic [CHAR_W-1:0] rotor_pos1,
    output logic [CHAR_W-1:0] rotor_pos2,
    input  logic [CHAR_W-1:0] rotor_result,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic              accept_c;
    logic              load_c;
    logic              step_c;
    logic              capture_c;
    logic              release_c;
    logic              pass_c;
    logic [CHAR_W-1:0] char_q;
    logic [CNT_W-1:0]  settle_cnt;

    // Codes beyond the alphabet (space/punctuation) bypass stepping and the chain.
    assign pass_c = (char_q >= CHAR_W'(ALPHA));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        load_c     = 1'b0;
        step_c     = 1'b0;
        capture_c  = 1'b0;
        release_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    next_state = STEP;
                end else if (key_load) begin
                    load_c = 1'b1;
                end
            end
            STEP: begin
                step_c     = ~pass_c;
                next_state = LOOK;
            end
            LOOK: begin
                if (settle_cnt == CNT_LAST) begin
                    capture_c  = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_c  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q     <= '0;
            rotor_char <= '0;
            out_char   <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            in_ready <= (next_state == IDLE);
            busy     <= (next_state != IDLE);
            if (accept_c)      char_q     <= in_char;
            if (state == STEP) rotor_char <= char_q;
            settle_cnt <= ((state == LOOK) && !capture_c) ? settle_cnt + CNT_W'(1) : '0;
            if (capture_c) begin
                out_char  <= pass_c ? rotor_char : rotor_result;
                out_valid <= 1'b1;
            end else if (release_c) begin
                out_valid <= 1'b0;
            end
        end
    end

    rotor_position_stepper #(
        .NOTCH0 (NOTCH0),
        .NOTCH1 (NOTCH1)
    ) u_stepper (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .step     (step_c),
        .key_pos0 (key_pos0),
        .key_pos1 (key_pos1),
        .key_pos2 (key_pos2),
        .pos0     (rotor_pos0),
        .pos1     (rotor_pos1),
        .pos2     (rotor_pos2)
    );

endmodule

// File: tb/tb_enigma_char_sequencer.sv
// Directed bench for enigma_char_sequencer; chain modelled as (char + pos0) mod 26.
module tb_enigma_char_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_load;
    logic [4:0] key_pos0, key_pos1, key_pos2;
    logic       in_valid;
    logic [4:0] in_char;
    logic       in_ready;
    logic [4:0] rotor_char;
    logic [4:0] rotor_pos0, rotor_pos1, rotor_pos2;
    logic [4:0] rotor_result;
    logic       out_valid;
    logic [4:0] out_char;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rotor_result = 5'((32'(rotor_char) + 32'(rotor_pos0)) % 26);

    enigma_char_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_pos0     (key_pos0),
        .key_pos1     (key_pos1),
        .key_pos2     (key_pos2),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_ready     (in_ready),
        .rotor_char   (rotor_char),
        .rotor_pos0   (rotor_pos0),
        .rotor_pos1   (rotor_pos1),
        .rotor_pos2   (rotor_pos2),
        .rotor_result (rotor_result),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    typedef struct {
        logic [4:0] k0, k1, k2;
        logic [4:0] ch;
        logic [4:0] exp_out;
        logic [4:0] e0, e1, e2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        key_load = 1'b1;
        key_pos0 = a;
        key_pos1 = b;
        key_pos2 = c;
        tick();
        key_load = 1'b0;
    endtask

    // Accept one character and wait (bounded) for out_valid; returns edges since accept.
    task automatic send_char(input logic [4:0] c, output int lat);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [4:0] held;

        vecs[0] = '{k0:0,  k1:0,  k2:0,  ch:0,  exp_out:1,  e0:1,  e1:0,  e2:0};
        vecs[1] = '{k0:16, k1:0,  k2:0,  ch:5,  exp_out:22, e0:17, e1:1,  e2:0};
        vecs[2] = '{k0:16, k1:4,  k2:0,  ch:0,  exp_out:17, e0:17, e1:5,  e2:1};
        vecs[3] = '{k0:25, k1:25, k2:25, ch:3,  exp_out:3,  e0:0,  e1:25, e2:25};
        vecs[4] = '{k0:3,  k1:3,  k2:3,  ch:27, exp_out:27, e0:3,  e1:3,  e2:3};
        vecs[5] = '{k0:30, k1:28, k2:31, ch:10, exp_out:15, e0:5,  e1:2,  e2:5};
        vecs[6] = '{k0:3,  k1:4,  k2:7,  ch:25, exp_out:3,  e0:4,  e1:5,  e2:8};
        vecs[7] = '{k0:25, k1:4,  k2:25, ch:1,  exp_out:1,  e0:0,  e1:5,  e2:0};

        rst = 1'b1; key_load = 1'b0; key_pos0 = '0; key_pos1 = '0; key_pos2 = '0;
        in_valid = 1'b0; in_char = '0; out_ready = 1'b0;
        #12;
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset rotor_char", int'(rotor_char), 0);
        check("reset out_char", int'(out_char), 0);
        check("reset pos", int'({rotor_pos0, rotor_pos1, rotor_pos2}), 0);
        rst = 1'b0;
        tick();
        check("in_ready after reset", int'(in_ready), 1);

        foreach (vecs[i]) begin
            load_key(vecs[i].k0, vecs[i].k1, vecs[i].k2);
            send_char(vecs[i].ch, lat);
            check($sformatf("vec%0d latency", i), lat, 2);
            check($sformatf("vec%0d out_char", i), int'(out_char), int'(vecs[i].exp_out));
            check($sformatf("vec%0d pos0", i), int'(rotor_pos0), int'(vecs[i].e0));
            check($sformatf("vec%0d pos1", i), int'(rotor_pos1), int'(vecs[i].e1));
            check($sformatf("vec%0d pos2", i), int'(rotor_pos2), int'(vecs[i].e2));
            drain();
            check($sformatf("vec%0d out_valid drop", i), int'(out_valid), 0);
        end

        // Backpressure with an ignored key load during HOLD.
        load_key(0, 0, 0);
        send_char(2, lat);
        check("bp latency", lat, 2);
        held = out_char;
        check("bp out_char", int'(held), 3);
        for (int k = 0; k < 5; k++) begin
            key_load = (k == 2); key_pos0 = 9; key_pos1 = 9; key_pos2 = 9;
            tick();
            check($sformatf("bp%0d out_valid", k), int'(out_valid), 1);
            check($sformatf("bp%0d out_char", k), int'(out_char), int'(held));
            check($sformatf("bp%0d in_ready", k), int'(in_ready), 0);
            check($sformatf("bp%0d busy", k), int'(busy), 1);
        end
        key_load = 1'b0;
        drain();
        check("bp in_ready after", int'(in_ready), 1);
        check("bp pos after hold key", int'({rotor_pos0, rotor_pos1, rotor_pos2}), int'({5'd1, 5'd0, 5'd0}));

        // Simultaneous in_valid and key_load: character wins.
        key_load = 1'b1; key_pos0 = 10; key_pos1 = 10; key_pos2 = 10;
        send_char(0, lat);
        key_load = 1'b0;
        check("prio latency", lat, 2);
        check("prio out_char", int'(out_char), 2);
        check("prio pos", int'({rotor_pos0, rotor_pos1, rotor_pos2}), int'({5'd2, 5'd0, 5'd0}));
        drain();

        // out_ready already high on entry still gives a single out_valid cycle.
        out_ready = 1'b1;
        send_char(4, lat);
        check("early ready latency", lat, 2);
        check("early ready out_char", int'(out_char), 7);
        tick();
        check("early ready drop", int'(out_valid), 0);
        check("early ready idle", int'(in_ready), 1);
        out_ready = 1'b0;

        // Reset while in LOOK: drop the character asynchronously.
        in_valid = 1'b1; in_char = 5;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre-reset busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst rotor_char", int'(rotor_char), 0);
        check("async rst pos", int'({rotor_pos0, rotor_pos1, rotor_pos2}), 0);
        tick();
        rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (out_valid) seen++;
            end
            check("no result after reset", seen, 0);
        end
        check("in_ready after mid reset", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
